ram_sdp_sr_init: RTL and testbench
==================================

// Module: ram_sdp_sr_init
// PURPOSE
//   Simple dual-port synchronous RAM: one write port and one read port, both on a single clock.
//   After every reset, an internal FSM clears the whole array to INIT_VALUE before the ports go live.
//   Read latency is configurable.
//   Serves as the general message/LLR store in the decoder memory subsystem, replacing single-port RAMs where read and write must overlap.
// PARAMETERS
//   DATA_WIDTH    8                 word width, bits
//   ADDR_WIDTH    8                 address width, bits
//   RAM_DEPTH     1<<ADDR_WIDTH     number of words; legal range 2..2**ADDR_WIDTH
//   READ_LATENCY  1                 rd_en-to-rd_valid latency in cycles; legal values 1 or 2
//   INIT_VALUE    0                 DATA_WIDTH value written to every word by the clear sweep
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous reset, active high
//   init_done  out  1           1 = clear sweep finished, ports accept requests
//   wr_en      in   1           write request
//   wr_addr    in   ADDR_WIDTH  write address
//   wr_data    in   DATA_WIDTH  write data
//   rd_en      in   1           read request
//   rd_addr    in   ADDR_WIDTH  read address
//   rd_data    out  DATA_WIDTH  read data; valid when rd_valid=1
//   rd_valid   out  1           rd_data qualifier, one cycle per accepted read
//   req_err    out  1           one-cycle pulse: request received while init_done=0
//   par_inj    in   1           [PARITY_EN only] invert the stored parity bit of this write
//   par_err    out  1           [PARITY_EN only] parity mismatch on the word in rd_data
// BEHAVIOUR
//   - Reset values:
//     - On rst assertion, with no clock: init_done=0, rd_data=0, rd_valid=0, req_err=0, par_err=0.
//     - Read pipeline is flushed; FSM goes to CLEAR; sweep counter is 0.
//   - FSM CLEAR:
//     - Each cycle writes INIT_VALUE to mem[cnt], then cnt++.
//     - After the write at cnt=RAM_DEPTH-1, the FSM moves to READY.
//     - init_done rises exactly RAM_DEPTH cycles after the first clk edge with rst low.
//   - FSM READY: terminal state; only rst leaves it. rst during CLEAR restarts the sweep at 0.
//   - Requests during CLEAR: wr_en or rd_en is ignored (no write, no rd_valid).
//     req_err is registered and pulses 1 on the following cycle.
//   - Write (READY): with wr_en=1, mem[wr_addr]<=wr_data at the rising edge.
//     wr_addr >= RAM_DEPTH: the write is silently dropped.
//   - Read (READY): rd_en=1 at edge N gives rd_valid=1 and rd_data after edge N+READ_LATENCY-1.
//     That is, visible in cycle N+READ_LATENCY.
//     Back-to-back reads give one result per cycle, in order.
//     rd_data holds its last value while rd_valid=0.
//     rd_addr >= RAM_DEPTH returns INIT_VALUE with rd_valid=1.
//   - Same-address read and write in the same cycle: write-first; the read returns the new wr_data.
//     Different addresses are fully independent.
//   - A write at edge N is visible to any read issued at edge N or later.
//   - rst mid-read: in-flight reads are discarded; no rd_valid after reset release until a new rd_en.
// CONFIGURATION
//   PARITY_EN defined:
//     - Each word stores an extra bit: ^wr_data XOR par_inj.
//     - The clear sweep stores ^INIT_VALUE.
//     - par_err is aligned with rd_valid: it is 1 when the stored bit does not equal ^(stored data).
//     - On a write-first bypass, par_err reflects the bit being written.
//     - par_err is 0 whenever rd_valid=0.
//   PARITY_EN undefined:
//     - No parity storage; ports par_inj and par_err do not exist.
//     - All other behaviour is identical.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=4, RAM_DEPTH=16, INIT_VALUE=8'hA5)
//   1. Release rst, hold ports idle, count cycles -> init_done=1 after 16 cycles.
//      Then read all 16 addresses -> every rd_data=8'hA5.
//   2. Write mem[i]=i*3 for i=0..15, then read random addresses -> rd_data=addr*3.
//      Check for READY_LATENCY=1 and 2, rd_valid exactly READ_LATENCY cycles after rd_en.
//   3. Same cycle: wr_en=1 wr_addr=5 wr_data=8'h3C, rd_en=1 rd_addr=5 -> rd_data=8'h3C.
//      Same cycle with rd_addr=6 -> old mem[6].
//   4. Pulse rd_en and wr_en during CLEAR -> req_err=1 the next cycle, no rd_valid.
//      Memory afterwards is all 8'hA5.
//   5. Assert rst at sweep cnt=7 and mid back-to-back reads -> outputs 0 immediately.
//      Sweep restarts; init_done after 16 more cycles; no stray rd_valid.
//   6. [PARITY_EN] Write addr 2 with par_inj=1, then read it -> par_err=1 with rd_valid.
//      Rewrite with par_inj=0 and read -> par_err=0.

Source files
------------

// File: rtl/ram_sdp_sr_init.sv
// ram_sdp_sr_init: simple dual-port RAM (one write port, one read port, one clock).
// After every reset, a clear sweep writes INIT_VALUE to every word before the ports go live.
// The read latency is 1 or 2 cycles and is set by READ_LATENCY.
// Optional feature macro: PARITY_EN. When it is defined, each word stores a parity bit.
// It also adds the par_inj and par_err ports.
module ram_sdp_sr_init #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  req_err
`ifdef PARITY_EN
  ,
  input  logic                  par_inj,
  output logic                  par_err
`endif
);

  // Request/response contract: wr_en and rd_en are accepted on a rising edge only while
  // init_done=1. There is no back-pressure. Each accepted read produces exactly one
  // rd_valid cycle, READ_LATENCY cycles later, and results come back in issue order.
  // A request made while init_done=0 is dropped, and req_err pulses on the next cycle.

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int                    AW1       = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = AW1'(RAM_DEPTH);

  // FSM and sweep counter. state_q is the state to watch when debugging.
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;

  // Request qualification
  logic                  ready;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_go, rd_go, bypass;
  logic                  req_err_q, req_err_d;

  // Memory write port, shared by the clear sweep and the user write port
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_data [RAM_DEPTH];

  // Read pipeline
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Clear-sweep next state: one word per cycle, then park in READY
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d     = ST_READY;
        init_done_d = 1'b1;
        cnt_d       = '0;
      end
    end
  end

  // FSM registers. A reset during the sweep restarts it from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Request qualification, memory write mux and write-first read selection
  always_comb begin
    ready       = (state_q == ST_READY);
    wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    wr_go       = ready & wr_en & wr_in_range;
    rd_go       = ready & rd_en;
    bypass      = wr_go & (wr_addr == rd_addr);
    req_err_d   = ~ready & (wr_en | rd_en);

    mem_we = (state_q == ST_CLEAR) | wr_go;
    mem_wa = ready ? wr_addr : cnt_q;
    mem_wd = ready ? wr_data : INIT_VALUE;

    rd_word = INIT_VALUE;
    if (bypass) begin
      rd_word = wr_data;
    end else if (rd_in_range) begin
      rd_word = mem_data[rd_addr];
    end
  end

  // Storage array. It has no reset: the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_data[mem_wa] <= mem_wd;
    end
  end

  // Read pipeline next state. The output holds its last value between results.
  always_comb begin
    s1_valid_d = rd_go;
    s1_data_d  = rd_go ? rd_word : s1_data_q;
    src_valid  = (READ_LATENCY == 1) ? s1_valid_d : s1_valid_q;
    src_data   = (READ_LATENCY == 1) ? s1_data_d  : s1_data_q;
    rd_valid_d = src_valid;
    rd_data_d  = src_valid ? src_data : rd_data_q;
  end

  // Read pipeline registers. Reset discards any reads still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      req_err_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      req_err_q  <= req_err_d;
    end
  end

`ifdef PARITY_EN
  // Parity path: the stored bit is the data parity XOR par_inj, and it is checked on read.
  logic mem_par [RAM_DEPTH];
  logic par_wd;
  logic rd_perr;
  logic s1_perr_q, s1_perr_d;
  logic src_perr;
  logic par_err_q, par_err_d;

  // Parity bit to store. On a write-first hit, the error reflects the bit being written.
  always_comb begin
    par_wd  = ready ? ((^wr_data) ^ par_inj) : (^INIT_VALUE);
    rd_perr = 1'b0;
    if (bypass) begin
      rd_perr = par_inj;
    end else if (rd_in_range) begin
      rd_perr = mem_par[rd_addr] ^ (^mem_data[rd_addr]);
    end
    s1_perr_d = rd_go & rd_perr;
    src_perr  = (READ_LATENCY == 1) ? s1_perr_d : s1_perr_q;
    par_err_d = src_valid & src_perr;
  end

  // Parity storage, written alongside the data array
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_par[mem_wa] <= par_wd;
    end
  end

  // Parity error pipeline, kept aligned with rd_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_perr_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      s1_perr_q <= s1_perr_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign init_done = init_done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign req_err   = req_err_q;

endmodule

// File: tb/tb_ram_sdp_sr_init.sv
// tb_ram_sdp_sr_init: drives two instances of ram_sdp_sr_init, one with READ_LATENCY=1 and one
// with READ_LATENCY=2, from the same stimulus. Each instance is checked against its own
// queue of expected reads.
`timescale 1ns/1ps
module tb_ram_sdp_sr_init;

  localparam int         DW    = 8;
  localparam int         AW    = 4;
  localparam int         DEPTH = 16;
  localparam logic [7:0] INIT  = 8'hA5;

  typedef struct packed {
    logic [31:0]   due;
    logic          perr;
    logic [DW-1:0] data;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc     = 0;
  int rel_cnt = 0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rel_cnt <= rst ? 0 : rel_cnt + 1;
  end

  // ---------------- DUT signals ----------------
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          init_done1, rd_valid1, req_err1;
  logic          init_done2, rd_valid2, req_err2;
  logic [DW-1:0] rd_data1, rd_data2;
`ifdef PARITY_EN
  logic          par_inj = 1'b0;
  logic          par_err1, par_err2;
`endif

  ram_sdp_sr_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
                    .READ_LATENCY(1), .INIT_VALUE(INIT)) dut1 (
    .clk(clk), .rst(rst), .init_done(init_done1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .req_err(req_err1)
`ifdef PARITY_EN
    , .par_inj(par_inj), .par_err(par_err1)
`endif
  );

  ram_sdp_sr_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
                    .READ_LATENCY(2), .INIT_VALUE(INIT)) dut2 (
    .clk(clk), .rst(rst), .init_done(init_done2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .req_err(req_err2)
`ifdef PARITY_EN
    , .par_inj(par_inj), .par_err(par_err2)
`endif
  );

  // ---------------- model and scoreboard state ----------------
  logic [DW-1:0] model    [DEPTH];
  logic          model_pe [DEPTH];
  logic          model_ready = 1'b0;
  exp_t          exp_q1[$];
  exp_t          exp_q2[$];
  logic [DW-1:0] last1 = '0, last2 = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model[i]    = INIT;
      model_pe[i] = 1'b0;
    end
  endtask

  // Monitor for one instance: a result that is due must appear exactly now. Otherwise the
  // outputs must be idle and rd_data must hold the last result.
  task automatic mon(input int w);
    exp_t          e;
    logic          have;
    logic          v;
    logic [DW-1:0] d;
    have = 1'b0;
    e    = '0;
    v    = (w == 1) ? rd_valid1 : rd_valid2;
    d    = (w == 1) ? rd_data1  : rd_data2;
    if (w == 1 && exp_q1.size() > 0 && exp_q1[0].due <= 32'(cyc)) begin
      e = exp_q1.pop_front(); have = 1'b1;
    end
    if (w == 2 && exp_q2.size() > 0 && exp_q2[0].due <= 32'(cyc)) begin
      e = exp_q2.pop_front(); have = 1'b1;
    end
    if (have) begin
      check((w == 1) ? "rd_valid_L1" : "rd_valid_L2", v, 1);
      check((w == 1) ? "rd_data_L1" : "rd_data_L2", d, e.data);
`ifdef PARITY_EN
      check((w == 1) ? "par_err_L1" : "par_err_L2", (w == 1) ? par_err1 : par_err2, e.perr);
`endif
      if (w == 1) last1 = e.data; else last2 = e.data;
    end else begin
      check((w == 1) ? "stray_valid_L1" : "stray_valid_L2", v, 0);
      check((w == 1) ? "rd_hold_L1" : "rd_hold_L2", d, (w == 1) ? last1 : last2);
`ifdef PARITY_EN
      check((w == 1) ? "par_idle_L1" : "par_idle_L2", (w == 1) ? par_err1 : par_err2, 0);
`endif
    end
  endtask

  always @(negedge clk) begin
    mon(1);
    mon(2);
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic pinj, input logic re, input logic [AW-1:0] ra);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
`ifdef PARITY_EN
    par_inj = pinj;
`endif
    if (model_ready) begin
      if (we) begin
        model[wa]    = wd;
        model_pe[wa] = pinj;
      end
      if (re) begin
        e.data = model[ra];
        e.perr = model_pe[ra];
        e.due  = 32'(cyc + 1);
        exp_q1.push_back(e);
        e.due  = 32'(cyc + 2);
        exp_q2.push_back(e);
      end
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
`ifdef PARITY_EN
    par_inj = 1'b0;
`endif
    if (pinj) wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, '0, '0, 1'b0, 1'b1, a);
  endtask

  // Assert reset between clock edges and check that the outputs clear without a clock.
  task automatic reset_now();
    #2; rst = 1'b1; #1;
    check("rst_init_done_L1", init_done1, 0);
    check("rst_init_done_L2", init_done2, 0);
    check("rst_rd_data_L1", rd_data1, 0);
    check("rst_rd_data_L2", rd_data2, 0);
    check("rst_rd_valid_L1", rd_valid1, 0);
    check("rst_rd_valid_L2", rd_valid2, 0);
    check("rst_req_err_L1", req_err1, 0);
    check("rst_req_err_L2", req_err2, 0);
`ifdef PARITY_EN
    check("rst_par_err_L1", par_err1, 0);
    check("rst_par_err_L2", par_err2, 0);
`endif
    exp_q1.delete();
    exp_q2.delete();
    last1 = '0; last2 = '0;
    model_ready = 1'b0;
    model_clear();
  endtask

  task automatic release_rst();
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for init_done and check that it rose on the 16th edge after release.
  task automatic wait_init();
    int   lat1, lat2, guard;
    logic seen1, seen2;
    seen1 = init_done1; seen2 = init_done2;
    lat1 = seen1 ? rel_cnt : -1;
    lat2 = seen2 ? rel_cnt : -1;
    guard = 0;
    while (!(seen1 && seen2) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
      if (init_done1 && !seen1) begin seen1 = 1'b1; lat1 = rel_cnt; end
      if (init_done2 && !seen2) begin seen2 = 1'b1; lat2 = rel_cnt; end
    end
    check("init_latency_L1", 32'(lat1), DEPTH);
    check("init_latency_L2", 32'(lat2), DEPTH);
    model_ready = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(3);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] a, b;
    model_clear();

    // Reset values with no clock edge, then clear sweep timing and contents.
    #1;
    reset_now();
    release_rst();
    wait_init();
    read_all();

    // Fill with i*3, then random reads with occasional gaps.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, AW'(i), DW'(i * 3), 1'b0, 1'b0, '0);
    for (int i = 0; i < 30; i++) begin
      rd(AW'($urandom_range(0, DEPTH - 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // Same-cycle write/read: same address is write-first, a different address reads the old data.
    drive(1'b1, 4'd5, 8'h3C, 1'b0, 1'b1, 4'd5);
    drive(1'b1, 4'd5, 8'h77, 1'b0, 1'b1, 4'd6);
    rd(4'd5);
    idle(3);

    // Random mixed traffic, biased towards address collisions.
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      b = ($urandom_range(0, 2) == 0) ? a : AW'($urandom_range(0, DEPTH - 1));
      drive(1'($urandom_range(0, 1)), a, DW'($urandom_range(0, 255)), 1'b0,
            1'($urandom_range(0, 1)), b);
    end
    idle(3);

    // Requests during CLEAR are dropped and flagged on req_err for one cycle.
    reset_now();
    release_rst();
    idle(2);
    drive(1'b1, 4'd3, 8'hFF, 1'b0, 1'b1, 4'd3);
    check("req_err_pulse_L1", req_err1, 1);
    check("req_err_pulse_L2", req_err2, 1);
    idle(1);
    check("req_err_clear_L1", req_err1, 0);
    check("req_err_clear_L2", req_err2, 0);
    wait_init();
    read_all();

    // Reset at sweep count 7: the sweep restarts from word 0.
    reset_now();
    release_rst();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    check("sweep_cnt_at_reset", 32'(rel_cnt), 7);
    reset_now();
    release_rst();
    wait_init();

    // Reset with back-to-back reads in flight: no stray rd_valid afterwards.
    drive(1'b1, 4'd9, 8'h5A, 1'b0, 1'b0, '0);
    rd(4'd9);
    rd(4'd9);
    reset_now();
    release_rst();
    wait_init();
    idle(4);
    rd(4'd9);
    idle(3);

`ifdef PARITY_EN
    // Parity injection, clean rewrite, and an injected parity bit seen through the bypass.
    drive(1'b1, 4'd2, 8'h81, 1'b1, 1'b0, '0);
    rd(4'd2);
    drive(1'b1, 4'd2, 8'h81, 1'b0, 1'b0, '0);
    rd(4'd2);
    drive(1'b1, 4'd4, 8'h13, 1'b1, 1'b1, 4'd4);
    rd(4'd4);
    idle(3);
`endif

    check("drain_L1", 32'(exp_q1.size()), 0);
    check("drain_L2", 32'(exp_q2.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
